fir_mac_sequencer: RTL and testbench

- Time-multiplexed 16-tap FIR engine controller with one shared 12x12 signed multiplier and accumulator.
- Pops one sample from the input FIFO and scans the 16 taps in 16 cycles, selecting each coefficient through an external coefficient mux.
- Rounds and saturates the sum, then pushes the result into the output FIFO.
- Runs only while enabled by the coefficient/control block (its en_fir_o drives en_fir_i).

---
 rtl/fir_mac_sequencer.sv | 144 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 16-tap time-multiplexed FIR controller.
// One shared signed MAC, round/saturate, FIFO handshakes.
module fir_mac_sequencer #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 28,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 11
) (
  input  logic              clk_100MHz_i,
  input  logic              rst_i,
  input  logic              en_fir_i,
  input  logic              empty_i,
  output logic              rd_o,
  input  logic [DATA_W-1:0] sample_i,
  output logic [3:0]        coef_sel_o,
  input  logic [DATA_W-1:0] coef_i,
  input  logic              full_out_i,
  output logic              wr_o,
  output logic [OUT_W-1:0]  y_o,
  output logic              busy_o,
  output logic              ovf_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_MAC,
    S_ROUND,
    S_WRITE
  } state_e;

  localparam int PW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_e state_q, state_d;
  logic [3:0] wptr_q, wptr_d;
  logic [3:0] k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic ovf_q, ovf_d;
  logic signed [DATA_W-1:0] ring_q [16];
  logic signed [DATA_W-1:0] ring_d [16];

  logic [3:0]               tap_idx;
  logic signed [DATA_W-1:0] tap;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic                     clip_hi;
  logic                     clip_lo;
  logic [OUT_W-1:0]         y_sat;

  // Tap k looks back k samples from the newest entry.
  assign tap_idx  = wptr_q - k_q;
  assign tap      = ring_q[tap_idx];
  assign prod     = tap * $signed(coef_i);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  assign shifted = acc_q >>> SHIFT;
  assign clip_hi = shifted > Y_MAX;
  assign clip_lo = shifted < Y_MIN;
  assign y_sat   = clip_hi ? Y_MAX[OUT_W-1:0] :
                   clip_lo ? Y_MIN[OUT_W-1:0] :
                   shifted[OUT_W-1:0];

  assign y_o    = y_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q != S_IDLE);

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    k_d        = k_q;
    acc_d      = acc_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    ring_d     = ring_q;
    rd_o       = 1'b0;
    wr_o       = 1'b0;
    coef_sel_o = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (en_fir_i && !empty_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_o    = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        wptr_d         = wptr_q + 4'd1;
        ring_d[wptr_d] = sample_i;
        acc_d          = '0;
        k_d            = 4'd0;
        state_d        = S_MAC;
      end
      S_MAC: begin
        coef_sel_o = k_q;
        acc_d      = acc_q + prod_ext;
        k_d        = k_q + 4'd1;
        if (k_q == 4'd15) state_d = S_ROUND;
      end
      S_ROUND: begin
        y_d = y_sat;
        if (clip_hi || clip_lo) ovf_d = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!full_out_i) begin
          wr_o    = 1'b1;
          state_d = (en_fir_i && !empty_i) ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, history ring and accumulator registers.
  always_ff @(posedge clk_100MHz_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      wptr_q  <= 4'd0;
      k_q     <= 4'd0;
      acc_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 16; i++) ring_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      ring_q  <= ring_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: two instances (SHIFT=0 and default)
// in lockstep against a plain-arithmetic FIR model.
module tb_fir_mac_sequencer;

  localparam int DW = 12;
  localparam int OW = 16;

  typedef struct {
    logic signed [DW-1:0] sample;
    logic signed [OW-1:0] exp_y;
    logic                 exp_ovf;
  } vec_t;

  typedef struct {
    int y0;
    bit o0;
    int y1;
    bit o1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic empty;
  logic full;
  logic [DW-1:0] sample;
  logic signed [DW-1:0] coefs [16];

  logic rd_a, wr_a, busy_a, ovf_a;
  logic rd_b, wr_b, busy_b, ovf_b;
  logic [3:0] sel_a, sel_b;
  logic [DW-1:0] coef_a, coef_b;
  logic signed [OW-1:0] y_a, y_b;

  assign coef_a = coefs[sel_a];
  assign coef_b = coefs[sel_b];

  fir_mac_sequencer #(.SHIFT(0)) dut_a (
    .clk_100MHz_i(clk),
    .rst_i(rst_n),
    .en_fir_i(en),
    .empty_i(empty),
    .rd_o(rd_a),
    .sample_i(sample),
    .coef_sel_o(sel_a),
    .coef_i(coef_a),
    .full_out_i(full),
    .wr_o(wr_a),
    .y_o(y_a),
    .busy_o(busy_a),
    .ovf_o(ovf_a)
  );

  fir_mac_sequencer dut_b (
    .clk_100MHz_i(clk),
    .rst_i(rst_n),
    .en_fir_i(en),
    .empty_i(empty),
    .rd_o(rd_b),
    .sample_i(sample),
    .coef_sel_o(sel_b),
    .coef_i(coef_b),
    .full_out_i(full),
    .wr_o(wr_b),
    .y_o(y_b),
    .busy_o(busy_b),
    .ovf_o(ovf_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  int fifo [$];
  exp_t expq [$];
  int hist [16];
  bit m_ovf0, m_ovf1;
  vec_t tbl [16];
  exp_t m_e;
  int m_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int sat(longint acc, int sh, output bit clip);
    longint t;
    t = acc >>> sh;
    clip = 1'b0;
    if (t > 32767) begin t = 32767; clip = 1'b1; end
    if (t < -32768) begin t = -32768; clip = 1'b1; end
    return int'(t);
  endfunction

  // Direct-form FIR: newest sample times coefficient 0, etc.
  task automatic model_pop(int s);
    exp_t e;
    longint acc;
    bit c;
    acc = 0;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    for (int k = 0; k < 16; k++)
      acc += longint'(hist[k]) * longint'(coefs[k]);
    e.y0 = sat(acc, 0, c);
    m_ovf0 = m_ovf0 | c;
    e.o0 = m_ovf0;
    e.y1 = sat(acc, 11, c);
    m_ovf1 = m_ovf1 | c;
    e.o1 = m_ovf1;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    expq.delete();
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
  endtask

  // Input FIFO emulation and output scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_a) begin
        checks++;
        if (fifo.size() == 0 || !rd_b || wr_a) begin
          errors++;
          $display("FAIL rd_pop: fifo=%0d rd_b=%0d wr_a=%0d",
                   fifo.size(), rd_b, wr_a);
        end else begin
          m_s = fifo.pop_front();
          sample = m_s[DW-1:0];
          model_pop(m_s);
          empty = (fifo.size() == 0);
        end
      end
      if (wr_a) begin
        if (expq.size() == 0 || !wr_b) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: wr_b=%0d", wr_b);
        end else begin
          m_e = expq.pop_front();
          chk("sb_y_shift0", y_a, m_e.y0);
          chk("sb_ovf_shift0", ovf_a, m_e.o0);
          chk("sb_y_shift11", y_b, m_e.y1);
          chk("sb_ovf_shift11", ovf_b, m_e.o1);
        end
      end
      if (!busy_a) chk("sel_idle", sel_a, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int s);
    fifo.push_back(s);
    empty = 1'b0;
  endtask

  task automatic wait_rd(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rd_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_wr(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (wr_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_rd"}, rd_a | rd_b, 0);
    chk({tag, "_wr"}, wr_a | wr_b, 0);
    chk({tag, "_sel"}, sel_a | sel_b, 0);
    chk({tag, "_y_a"}, y_a, 0);
    chk({tag, "_y_b"}, y_b, 0);
    chk({tag, "_busy"}, busy_a | busy_b, 0);
    chk({tag, "_ovf"}, ovf_a | ovf_b, 0);
  endtask

  task automatic run_impulse(string tag);
    bit ok;
    for (int i = 0; i < 16; i++) begin
      tick();
      push(tbl[i].sample);
      wait_wr(60, ok);
      chk({tag, "_timeout"}, ok, 1);
      chk({tag, "_y"}, y_a, tbl[i].exp_y);
      chk({tag, "_ovf"}, ovf_a, tbl[i].exp_ovf);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0 [16];
    bit ok;
    int bad;
    int nb;
    int npush;
    longint t0;
    logic signed [OW-1:0] yhold;

    c0 = '{-99, 65, 136, 33, -156, -86, 376, 854,
           854, 376, -86, -156, 33, 136, 65, -99};
    for (int i = 0; i < 16; i++) begin
      coefs[i] = c0[i][DW-1:0];
      tbl[i].sample = (i == 0) ? 12'sd1 : 12'sd0;
      tbl[i].exp_y = c0[i][OW-1:0];
      tbl[i].exp_ovf = 1'b0;
    end
    model_reset();

    rst_n = 1'b0;
    en = 1'b0;
    empty = 1'b1;
    full = 1'b0;
    sample = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Enabled but input empty: stay idle.
    tick();
    en = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      bad += int'(rd_a | busy_a);
    end
    chk("empty_no_rd", bad, 0);

    run_impulse("impulse");

    // Latency and back-to-back period.
    tick();
    push(111);
    push(-222);
    wait_rd(40, ok);
    chk("lat_rd_timeout", ok, 1);
    t0 = cyc;
    chk("lat_busy_T", busy_a, 1);
    nb = 0;
    bad = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (!busy_a) nb++;
      if (i < 19 && (wr_a || rd_a)) bad++;
    end
    chk("lat_wr_T19", wr_a, 1);
    chk("lat_busy_span", nb, 0);
    chk("lat_no_early_pulse", bad, 0);
    wait_rd(40, ok);
    chk("lat_rd2_timeout", ok, 1);
    chk("lat_period", cyc - t0, 20);
    wait_wr(40, ok);
    chk("lat_wr2_timeout", ok, 1);

    // Backpressure for 10 cycles in WRITE.
    tick();
    full = 1'b1;
    push(500);
    push(-7);
    wait_rd(40, ok);
    chk("bp_rd_timeout", ok, 1);
    repeat (19) @(negedge clk);
    yhold = y_a;
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      if (wr_a || rd_a || y_a != yhold || !busy_a) bad++;
    end
    chk("bp_hold", bad, 0);
    tick();
    full = 1'b0;
    @(negedge clk);
    chk("bp_release_wr", wr_a, 1);
    wait_wr(40, ok);
    chk("bp_drain_timeout", ok, 1);

    // Enable dropped mid-MAC.
    tick();
    push(5);
    push(6);
    push(7);
    wait_rd(40, ok);
    chk("en_rd_timeout", ok, 1);
    repeat (8) @(negedge clk);
    tick();
    en = 1'b0;
    wait_wr(40, ok);
    chk("en_drop_wr", ok, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      bad += int'(rd_a | busy_a | wr_a);
    end
    chk("en_drop_idle", bad, 0);
    tick();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_wr(60, ok);
      chk("en_drain_timeout", ok, 1);
    end

    // Asynchronous reset at tap 7.
    tick();
    push(42);
    wait_rd(40, ok);
    chk("rst_rd_timeout", ok, 1);
    repeat (9) @(posedge clk);
    #1;
    chk("rst_k7_sel", sel_a, 7);
    chk("rst_pre_y_nonzero", (y_a != 0), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      bad += int'(wr_a | rd_a);
    end
    chk("rst_no_wr", bad, 0);
    rst_n = 1'b1;
    run_impulse("impulse_after_rst");

    // Random coefficients, samples and backpressure.
    tick();
    for (int i = 0; i < 16; i++)
      coefs[i] = DW'(int'($urandom_range(0, 4095)) - 2048);
    npush = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      full = ($urandom_range(0, 3) == 0);
      if (npush < 40 && $urandom_range(0, 9) == 0) begin
        push(int'($urandom_range(0, 4095)) - 2048);
        npush++;
      end
      if (npush == 40 && fifo.size() == 0 &&
          expq.size() == 0 && !busy_a) break;
    end
    full = 1'b0;
    chk("rand_drained", fifo.size() + expq.size(), 0);
    chk("rand_all_pushed", npush, 40);

    // Saturation with default scaling.
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) coefs[i] = -12'sd2048;
    tick();
    for (int i = 0; i < 16; i++) push(-2048);
    for (int i = 0; i < 16; i++) begin
      wait_wr(60, ok);
      chk("sat_timeout", ok, 1);
      if (i == 14) begin
        chk("sat_y15", y_b, 30720);
        chk("sat_ovf15", ovf_b, 0);
      end
    end
    chk("sat_y16", y_b, 32767);
    chk("sat_ovf16", ovf_b, 1);
    repeat (50) @(negedge clk);
    chk("sat_ovf_sticky", ovf_b, 1);
    chk("sat_idle", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
